axis_loop_tester: RTL and testbench

- Synthesizable AXI-Stream traffic generator plus self-checker for senter→channel→receiver loopback runs, on the FPGA or in simulation.
- The generator drives the senter input stream with a deterministic incrementing word sequence, optional tlast framing and optional pseudo-random tvalid gaps.
- The checker consumes the receiver output stream with optional pseudo-random tready backpressure, compares each word to the expected sequence, and reports counts, errors and a pass/fail verdict.

---
 rtl/axis_loop_tester.sv | 267 ++++++++++++++++++++++++++
 tb/tb_axis_loop_tester.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_loop_tester.sv
// -----------------------------------------------------------------------------
// axis_loop_tester
//
// AXI-Stream loopback traffic generator plus checker. The generator sends an
// incrementing word sequence (BASE_WORD + index) with optional tlast framing
// and optional pseudo-random tvalid gaps. The checker accepts the returning
// stream with optional pseudo-random tready throttling, compares every word
// against the same sequence and reports counts, errors and a verdict.
//
// Ports
//   clk_i, rst_i            clock, synchronous active-high reset
//   start_i                 one-cycle pulse, starts a run from IDLE or DONE
//   num_words_i, pkt_len_i  run length and packet length (latched on start)
//   tx_gap_en_i             enable pseudo-random tvalid gaps
//   rx_throttle_en_i        enable pseudo-random tready deassertion
//   tx_t*                   generator AXI-Stream master
//   rx_t*                   checker AXI-Stream slave (rx_tlast_i is ignored)
//   busy_o, done_o, pass_o, timeout_o     run status
//   tx_cnt_o, rx_cnt_o, err_cnt_o, first_err_data_o   run statistics
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | after reset, waiting for start
// RUN   | generator sending, checker receiving
// DRAIN | all words sent, waiting for the remaining words to return
// DONE  | run finished (normally or by watchdog), verdict on pass_o
// -----------------------------------------------------------------------------
module axis_loop_tester #(
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_WORD      = DATA_WIDTH'(32'h1234_5670),
    parameter int                    CNT_WIDTH      = 16,
    parameter logic [15:0]           LFSR_SEED_TX   = 16'hACE1,
    parameter logic [15:0]           LFSR_SEED_RX   = 16'h1D2B,
    parameter int                    TIMEOUT_CYCLES = 4096
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic [CNT_WIDTH-1:0]    num_words_i,
    input  logic [CNT_WIDTH-1:0]    pkt_len_i,
    input  logic                    tx_gap_en_i,
    input  logic                    rx_throttle_en_i,
    output logic [DATA_WIDTH-1:0]   tx_tdata_o,
    output logic [DATA_WIDTH/8-1:0] tx_tkeep_o,
    output logic                    tx_tlast_o,
    output logic                    tx_tvalid_o,
    input  logic                    tx_tready_i,
    input  logic [DATA_WIDTH-1:0]   rx_tdata_i,
    input  logic [DATA_WIDTH/8-1:0] rx_tkeep_i,
    input  logic                    rx_tlast_i,
    input  logic                    rx_tvalid_i,
    output logic                    rx_tready_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    pass_o,
    output logic                    timeout_o,
    output logic [CNT_WIDTH-1:0]    tx_cnt_o,
    output logic [CNT_WIDTH-1:0]    rx_cnt_o,
    output logic [CNT_WIDTH-1:0]    err_cnt_o,
    output logic [DATA_WIDTH-1:0]   first_err_data_o
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int WD_W   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Fibonacci form
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

    state_t                  state_q, state_d;
    logic [CNT_WIDTH-1:0]    num_words_q, num_words_d;
    logic [CNT_WIDTH-1:0]    pkt_len_q, pkt_len_d;
    logic                    gap_en_q, gap_en_d;
    logic                    throttle_en_q, throttle_en_d;
    logic [CNT_WIDTH-1:0]    tx_cnt_q, tx_cnt_d;
    logic [CNT_WIDTH-1:0]    rx_cnt_q, rx_cnt_d;
    logic [CNT_WIDTH-1:0]    pkt_cnt_q, pkt_cnt_d;
    logic [DATA_WIDTH-1:0]   tx_data_q, tx_data_d;
    logic                    tx_valid_q, tx_valid_d;
    logic [CNT_WIDTH-1:0]    err_cnt_q, err_cnt_d;
    logic [DATA_WIDTH-1:0]   first_err_q, first_err_d;
    logic                    timeout_q, timeout_d;
    logic [WD_W-1:0]         wd_q, wd_d;
    logic [15:0]             lfsr_tx_q, lfsr_tx_d;
    logic [15:0]             lfsr_rx_q, lfsr_rx_d;

    logic                    run_active;
    logic                    tx_hs;
    logic                    rx_rdy;
    logic                    rx_hs;
    logic                    rx_bad;
    logic                    pkt_last;
    logic                    word_last;
    logic [DATA_WIDTH-1:0]   rx_expect;

    logic unused_rx_tlast;
    assign unused_rx_tlast = rx_tlast_i;

    assign run_active = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign tx_hs      = tx_valid_q && tx_tready_i;
    // Stop accepting once the run's word count is reached so rx_cnt never
    // overshoots, even if the channel injects extra words.
    assign rx_rdy     = run_active && (rx_cnt_q != num_words_q)
                        && !(throttle_en_q && lfsr_rx_q[0]);
    assign rx_hs      = rx_rdy && rx_tvalid_i;
    assign rx_expect  = BASE_WORD + DATA_WIDTH'(rx_cnt_q);
    assign rx_bad     = (rx_tdata_i != rx_expect) || (rx_tkeep_i != {KEEP_W{1'b1}});

    // pkt_cnt tracks tx_cnt mod pkt_len without a divider.
    assign pkt_last   = (pkt_len_q != '0)
                        && (({1'b0, pkt_cnt_q} + (CNT_WIDTH+1)'(1)) == {1'b0, pkt_len_q});
    assign word_last  = ({1'b0, tx_cnt_q} + (CNT_WIDTH+1)'(1)) == {1'b0, num_words_q};

    always_comb begin
        state_d       = state_q;
        num_words_d   = num_words_q;
        pkt_len_d     = pkt_len_q;
        gap_en_d      = gap_en_q;
        throttle_en_d = throttle_en_q;
        tx_cnt_d      = tx_cnt_q;
        rx_cnt_d      = rx_cnt_q;
        pkt_cnt_d     = pkt_cnt_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        err_cnt_d     = err_cnt_q;
        first_err_d   = first_err_q;
        timeout_d     = timeout_q;
        wd_d          = wd_q;
        lfsr_tx_d     = lfsr_tx_q;
        lfsr_rx_d     = lfsr_rx_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    num_words_d   = num_words_i;
                    pkt_len_d     = pkt_len_i;
                    gap_en_d      = tx_gap_en_i;
                    throttle_en_d = rx_throttle_en_i;
                    tx_cnt_d      = '0;
                    rx_cnt_d      = '0;
                    pkt_cnt_d     = '0;
                    tx_data_d     = BASE_WORD;
                    tx_valid_d    = 1'b0;
                    err_cnt_d     = '0;
                    first_err_d   = '0;
                    timeout_d     = 1'b0;
                    wd_d          = WD_LOAD;
                    state_d       = (num_words_i == '0) ? S_DONE : S_RUN;
                end
            end

            S_RUN, S_DRAIN: begin
                lfsr_rx_d = lfsr_step(lfsr_rx_q);

                if (state_q == S_RUN) begin
                    if (tx_hs) begin
                        tx_cnt_d  = tx_cnt_q + CNT_WIDTH'(1);
                        tx_data_d = tx_data_q + DATA_WIDTH'(1);
                        pkt_cnt_d = pkt_last ? '0 : pkt_cnt_q + CNT_WIDTH'(1);
                        lfsr_tx_d = lfsr_step(lfsr_tx_q);
                    end else if (!tx_valid_q) begin
                        lfsr_tx_d = lfsr_step(lfsr_tx_q);
                    end
                    // Gap decision only while idle or on a completed beat, so an
                    // offered word is never withdrawn.
                    if (!tx_valid_q || tx_hs) begin
                        tx_valid_d = (tx_cnt_d != num_words_q) && !(gap_en_q && lfsr_tx_q[0]);
                    end
                end

                if (rx_hs) begin
                    rx_cnt_d = rx_cnt_q + CNT_WIDTH'(1);
                    if (rx_bad) begin
                        if (err_cnt_q == '0) begin
                            first_err_d = rx_tdata_i;
                        end
                        if (err_cnt_q != {CNT_WIDTH{1'b1}}) begin
                            err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
                        end
                    end
                end

                if (rx_hs) begin
                    wd_d = WD_LOAD;
                end else if (wd_q != '0) begin
                    wd_d = wd_q - WD_W'(1);
                end

                if (!rx_hs && (wd_q == '0)) begin
                    timeout_d  = 1'b1;
                    tx_valid_d = 1'b0;
                    state_d    = S_DONE;
                end else if ((rx_cnt_d == num_words_q) && (tx_cnt_d == num_words_q)) begin
                    state_d = S_DONE;
                end else if ((state_q == S_RUN) && (tx_cnt_d == num_words_q)) begin
                    state_d = S_DRAIN;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= S_IDLE;
            num_words_q   <= '0;
            pkt_len_q     <= '0;
            gap_en_q      <= 1'b0;
            throttle_en_q <= 1'b0;
            tx_cnt_q      <= '0;
            rx_cnt_q      <= '0;
            pkt_cnt_q     <= '0;
            tx_data_q     <= '0;
            tx_valid_q    <= 1'b0;
            err_cnt_q     <= '0;
            first_err_q   <= '0;
            timeout_q     <= 1'b0;
            wd_q          <= '0;
            lfsr_tx_q     <= LFSR_SEED_TX;
            lfsr_rx_q     <= LFSR_SEED_RX;
        end else begin
            state_q       <= state_d;
            num_words_q   <= num_words_d;
            pkt_len_q     <= pkt_len_d;
            gap_en_q      <= gap_en_d;
            throttle_en_q <= throttle_en_d;
            tx_cnt_q      <= tx_cnt_d;
            rx_cnt_q      <= rx_cnt_d;
            pkt_cnt_q     <= pkt_cnt_d;
            tx_data_q     <= tx_data_d;
            tx_valid_q    <= tx_valid_d;
            err_cnt_q     <= err_cnt_d;
            first_err_q   <= first_err_d;
            timeout_q     <= timeout_d;
            wd_q          <= wd_d;
            lfsr_tx_q     <= lfsr_tx_d;
            lfsr_rx_q     <= lfsr_rx_d;
        end
    end

    assign tx_tdata_o       = tx_data_q;
    assign tx_tkeep_o       = {KEEP_W{tx_valid_q}};
    assign tx_tlast_o       = tx_valid_q && (pkt_last || word_last);
    assign tx_tvalid_o      = tx_valid_q;
    assign rx_tready_o      = rx_rdy;
    assign busy_o           = run_active;
    assign done_o           = (state_q == S_DONE);
    assign pass_o           = (state_q == S_DONE) && (err_cnt_q == '0) && !timeout_q;
    assign timeout_o        = timeout_q;
    assign tx_cnt_o         = tx_cnt_q;
    assign rx_cnt_o         = rx_cnt_q;
    assign err_cnt_o        = err_cnt_q;
    assign first_err_data_o = first_err_q;

endmodule

// File: tb/tb_axis_loop_tester.sv
// -----------------------------------------------------------------------------
// tb_axis_loop_tester
//
// Bench for axis_loop_tester. A channel model selected by `mode` connects the
// generator to the checker (direct wire, ready toggling, 4-deep FIFO, or a
// dead receiver). Expected tx words are queued when a run starts and popped on
// every tx handshake; each run's final statistics come from a row table.
// -----------------------------------------------------------------------------
module tb_axis_loop_tester;

    localparam logic [31:0] BASE = 32'h1234_5670;
    localparam int M_NONE   = 0;
    localparam int M_DIRECT = 1;
    localparam int M_TOGGLE = 2;
    localparam int M_FIFO   = 3;
    localparam int M_STUCK  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] num_words;
    logic [15:0] pkt_len;
    logic        tx_gap_en;
    logic        rx_throttle_en;
    logic [31:0] tx_tdata;
    logic [3:0]  tx_tkeep;
    logic        tx_tlast;
    logic        tx_tvalid;
    logic        tx_tready;
    logic [31:0] rx_tdata;
    logic [3:0]  rx_tkeep;
    logic        rx_tlast;
    logic        rx_tvalid;
    logic        rx_tready;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [15:0] tx_cnt;
    logic [15:0] rx_cnt;
    logic [15:0] err_cnt;
    logic [31:0] first_err_data;

    always #5 clk = ~clk;

    axis_loop_tester dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .start_i          (start),
        .num_words_i      (num_words),
        .pkt_len_i        (pkt_len),
        .tx_gap_en_i      (tx_gap_en),
        .rx_throttle_en_i (rx_throttle_en),
        .tx_tdata_o       (tx_tdata),
        .tx_tkeep_o       (tx_tkeep),
        .tx_tlast_o       (tx_tlast),
        .tx_tvalid_o      (tx_tvalid),
        .tx_tready_i      (tx_tready),
        .rx_tdata_i       (rx_tdata),
        .rx_tkeep_i       (rx_tkeep),
        .rx_tlast_i       (rx_tlast),
        .rx_tvalid_i      (rx_tvalid),
        .rx_tready_o      (rx_tready),
        .busy_o           (busy),
        .done_o           (done),
        .pass_o           (pass),
        .timeout_o        (timeout),
        .tx_cnt_o         (tx_cnt),
        .rx_cnt_o         (rx_cnt),
        .err_cnt_o        (err_cnt),
        .first_err_data_o (first_err_data)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // ---------------- channel model ----------------
    int          mode = M_NONE;
    int          corrupt_idx = -1;
    int          rx_idx;
    logic        tog;
    logic [31:0] fifo_mem [4];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    int          fifo_cnt;

    always_comb begin
        tx_tready = 1'b0;
        rx_tvalid = 1'b0;
        rx_tdata  = 32'h0;
        rx_tkeep  = 4'h0;
        rx_tlast  = 1'b0;
        case (mode)
            M_DIRECT: begin
                tx_tready = rx_tready;
                rx_tvalid = tx_tvalid;
                rx_tdata  = tx_tdata ^ ((rx_idx == corrupt_idx) ? 32'h1 : 32'h0);
                rx_tkeep  = tx_tkeep;
                rx_tlast  = tx_tlast;
            end
            M_TOGGLE: begin
                tx_tready = tog;
                rx_tvalid = tx_tvalid & tog;
                rx_tdata  = tx_tdata;
                rx_tkeep  = tx_tkeep;
                rx_tlast  = tx_tlast;
            end
            M_FIFO: begin
                tx_tready = (fifo_cnt < 4);
                rx_tvalid = (fifo_cnt > 0);
                rx_tdata  = fifo_mem[rd_ptr];
                rx_tkeep  = 4'hF;
            end
            M_STUCK: begin
                tx_tready = 1'b1;
            end
            default: ;
        endcase
    end

    always @(posedge clk) begin
        tog <= rst ? 1'b0 : ~tog;
        if (start) rx_idx <= 0;
        else if (rx_tvalid && rx_tready) rx_idx <= rx_idx + 1;
    end

    always @(posedge clk) begin
        if (rst || mode != M_FIFO) begin
            wr_ptr   <= 2'd0;
            rd_ptr   <= 2'd0;
            fifo_cnt <= 0;
        end else begin
            if (tx_tvalid && tx_tready) begin
                fifo_mem[wr_ptr] <= tx_tdata;
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (rx_tvalid && rx_tready) rd_ptr <= rd_ptr + 2'd1;
            fifo_cnt <= fifo_cnt + ((tx_tvalid && tx_tready) ? 1 : 0)
                                 - ((rx_tvalid && rx_tready) ? 1 : 0);
        end
    end

    // ---------------- scoreboard on the generator side ----------------
    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t sb_q[$];
    int   tx_pops = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!rst && tx_tvalid && tx_tready) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL tx_extra_word: actual data=0x%0h required no further word", tx_tdata);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("tx_word%0d_data", tx_pops), 64'(tx_tdata), 64'(e.data));
                check($sformatf("tx_word%0d_last", tx_pops), 64'(tx_tlast), 64'(e.last));
                check($sformatf("tx_word%0d_keep", tx_pops), 64'(tx_tkeep), 64'(4'hF));
            end
            tx_pops++;
        end
    end

    // Offered word must stay put until accepted.
    logic        chk_stable = 1'b0;
    logic        prev_pending = 1'b0;
    logic [31:0] prev_data;
    logic        prev_last;

    always @(negedge clk) begin
        if (chk_stable && prev_pending) begin
            check("tx_valid_held", 64'(tx_tvalid), 64'(1));
            check("tx_data_held", 64'(tx_tdata), 64'(prev_data));
            check("tx_last_held", 64'(tx_tlast), 64'(prev_last));
        end
        prev_pending = tx_tvalid && !tx_tready;
        prev_data    = tx_tdata;
        prev_last    = tx_tlast;
    end

    // ---------------- run helpers ----------------
    task automatic start_run(input int n, input int pkt, input bit gap, input bit thr);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e.data = BASE + 32'(i);
            e.last = ((pkt != 0) && (((i + 1) % pkt) == 0)) || ((i + 1) == n);
            sb_q.push_back(e);
        end
        num_words      = 16'(n);
        pkt_len        = 16'(pkt);
        tx_gap_en      = gap;
        rx_throttle_en = thr;
        start          = 1'b1;
        @(negedge clk);
        start          = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check({name, "_done_reached"}, 64'(done), 64'(1));
    endtask

    typedef struct {
        int          mode;
        int          n;
        int          pkt;
        bit          gap;
        bit          thr;
        int          corrupt;
        bit          exp_pass;
        int          exp_err;
        logic [31:0] exp_first;
        int          exp_cycles;
    } row_t;

    row_t rows[6];

    task automatic check_idle_zero(input string p);
        check({p, "_busy"}, 64'(busy), 64'(0));
        check({p, "_done"}, 64'(done), 64'(0));
        check({p, "_pass"}, 64'(pass), 64'(0));
        check({p, "_timeout"}, 64'(timeout), 64'(0));
        check({p, "_tx_cnt"}, 64'(tx_cnt), 64'(0));
        check({p, "_rx_cnt"}, 64'(rx_cnt), 64'(0));
        check({p, "_err_cnt"}, 64'(err_cnt), 64'(0));
        check({p, "_first_err"}, 64'(first_err_data), 64'(0));
        check({p, "_tvalid"}, 64'(tx_tvalid), 64'(0));
        check({p, "_tdata"}, 64'(tx_tdata), 64'(0));
        check({p, "_tkeep"}, 64'(tx_tkeep), 64'(0));
        check({p, "_tlast"}, 64'(tx_tlast), 64'(0));
        check({p, "_rx_tready"}, 64'(rx_tready), 64'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: actual=expired required=finished");
        $fatal(1, "time limit");
    end

    initial begin
        int   cyc;
        int   p0;
        int   k;
        string nm;

        rows[0] = '{M_DIRECT, 1000, 0, 1'b0, 1'b0, -1, 1'b1, 0, 32'h0, 1001};
        rows[1] = '{M_TOGGLE, 20,   8, 1'b0, 1'b0, -1, 1'b1, 0, 32'h0, 0};
        rows[2] = '{M_DIRECT, 16,   0, 1'b0, 1'b0,  5, 1'b0, 1, 32'h1234_5674, 17};
        rows[3] = '{M_FIFO,   500,  0, 1'b1, 1'b1, -1, 1'b1, 0, 32'h0, 0};
        rows[4] = '{M_DIRECT, 3,    1, 1'b0, 1'b0, -1, 1'b1, 0, 32'h0, 4};
        rows[5] = '{M_FIFO,   10,   3, 1'b1, 1'b0, -1, 1'b1, 0, 32'h0, 0};

        rst = 1'b1;
        start = 1'b0;
        num_words = 16'd0;
        pkt_len = 16'd0;
        tx_gap_en = 1'b0;
        rx_throttle_en = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_zero("idle");

        for (int r = 0; r < 6; r++) begin
            nm = $sformatf("row%0d", r);
            mode = rows[r].mode;
            corrupt_idx = rows[r].corrupt;
            chk_stable = 1'b1;
            start_run(rows[r].n, rows[r].pkt, rows[r].gap, rows[r].thr);
            check({nm, "_first_cycle_tvalid"}, 64'(tx_tvalid), 64'(0));
            check({nm, "_busy_after_start"}, 64'(busy), 64'(1));
            check({nm, "_done_cleared"}, 64'(done), 64'(0));
            wait_done(nm, 20000, cyc);
            if (rows[r].exp_cycles != 0)
                check({nm, "_done_latency"}, 64'(cyc), 64'(rows[r].exp_cycles));
            check({nm, "_pass"}, 64'(pass), 64'(rows[r].exp_pass));
            check({nm, "_err_cnt"}, 64'(err_cnt), 64'(rows[r].exp_err));
            check({nm, "_first_err"}, 64'(first_err_data), 64'(rows[r].exp_first));
            check({nm, "_timeout"}, 64'(timeout), 64'(0));
            check({nm, "_tx_cnt"}, 64'(tx_cnt), 64'(rows[r].n));
            check({nm, "_rx_cnt"}, 64'(rx_cnt), 64'(rows[r].n));
            check({nm, "_busy_end"}, 64'(busy), 64'(0));
            check({nm, "_rx_tready_end"}, 64'(rx_tready), 64'(0));
            check({nm, "_sb_empty"}, 64'(sb_q.size()), 64'(0));
            @(negedge clk);
            check({nm, "_done_held"}, 64'(done), 64'(1));
        end

        // Dead receiver: all words leave, none return, watchdog must fire.
        mode = M_STUCK;
        corrupt_idx = -1;
        start_run(4, 0, 1'b0, 1'b0);
        wait_done("wdog", 6000, cyc);
        check("wdog_latency", 64'(cyc), 64'(4096));
        check("wdog_timeout", 64'(timeout), 64'(1));
        check("wdog_pass", 64'(pass), 64'(0));
        check("wdog_tx_cnt", 64'(tx_cnt), 64'(4));
        check("wdog_rx_cnt", 64'(rx_cnt), 64'(0));
        check("wdog_busy", 64'(busy), 64'(0));
        check("wdog_sb_empty", 64'(sb_q.size()), 64'(0));

        // Reset in the middle of a run, then an empty run.
        mode = M_DIRECT;
        start_run(100, 0, 1'b0, 1'b0);
        p0 = tx_pops;
        k = 0;
        while ((tx_pops - p0) < 37 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check("mid_run_word37_reached", 64'((tx_pops - p0) >= 37), 64'(1));
        chk_stable = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb_q.delete();
        check_idle_zero("midrst");
        start_run(0, 0, 1'b0, 1'b0);
        check("empty_done", 64'(done), 64'(1));
        check("empty_pass", 64'(pass), 64'(1));
        check("empty_tx_cnt", 64'(tx_cnt), 64'(0));
        check("empty_busy", 64'(busy), 64'(0));
        check("empty_timeout", 64'(timeout), 64'(0));
        @(negedge clk);
        check("empty_tvalid", 64'(tx_tvalid), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
